// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam logic [2:0] F3_LW = 3'b010;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Loadable down-counter that times the MEM_LAT access cycles and flags the final one.
module mem_arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic last
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_r;

  // Load remaining-cycle count at grant, count down through the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= CW'(MEM_LAT - 1);
    end else if (run && (cnt_r != '0)) begin
      cnt_r <= cnt_r - 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and load/store,
// sequencing each granted access over MEM_LAT cycles followed by a one-cycle response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [2:0]    mem_funct3,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int SCW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_r;
  logic          owner_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic          we_r;
  logic [2:0]    funct3_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          flushed_r;
  logic          if_done_r;
  logic          d_done_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] d_rdata_r;
  logic [SCW-1:0] starve_cnt_r;

  logic grant_f_s;
  logic grant_d_s;
  logic starved_s;
  logic last_s;

  // Grant decision: data first (older instruction) unless fetch has been starved.
  always_comb begin
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    starved_s = (starve_cnt_r == SCW'(STARVE_MAX));
    if (state_r == ST_IDLE) begin
      grant_f_s = if_req & ~if_flush & (~d_req | starved_s);
      grant_d_s = d_req & ~grant_f_s;
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  mem_arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (grant_f_s | grant_d_s),
    .run  (state_r == ST_BUSY),
    .last (last_s)
  );

  // Starvation counter: consecutive data grants seen while fetch keeps requesting.
  always_ff @(posedge clk) begin
    if (rst || !if_req || grant_f_s) begin
      starve_cnt_r <= '0;
    end else if (grant_d_s && (starve_cnt_r != SCW'(STARVE_MAX))) begin
      starve_cnt_r <= starve_cnt_r + 1'b1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Access sequencer with latched payload, registered memory strobes and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWNER_IF;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      we_r       <= 1'b0;
      funct3_r   <= 3'b000;
      addr_r     <= '0;
      wdata_r    <= '0;
      flushed_r  <= 1'b0;
      if_done_r  <= 1'b0;
      d_done_r   <= 1'b0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_f_s || grant_d_s) begin
            state_r   <= ST_BUSY;
            owner_r   <= grant_d_s ? OWNER_D : OWNER_IF;
            mem_en_r  <= 1'b1;
            mem_we_r  <= grant_d_s & d_we;
            we_r      <= grant_d_s & d_we;
            funct3_r  <= grant_d_s ? d_funct3 : F3_LW;
            addr_r    <= grant_d_s ? d_addr : if_addr;
            wdata_r   <= grant_d_s ? d_wdata : '0;
            flushed_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          mem_we_r <= 1'b0;
          if ((owner_r == OWNER_IF) && if_flush) begin
            flushed_r <= 1'b1;
          end
          if (last_s) begin
            state_r  <= ST_RESP;
            mem_en_r <= 1'b0;
            if (owner_r == OWNER_D) begin
              d_done_r <= 1'b1;
              if (!we_r) begin
                d_rdata_r <= mem_rdata;
              end
            end else if (!flushed_r && !if_flush) begin
              if_done_r  <= 1'b1;
              if_rdata_r <= mem_rdata;
            end
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          if_done_r <= 1'b0;
          d_done_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_en_r  <= 1'b0;
          mem_we_r  <= 1'b0;
          if_done_r <= 1'b0;
          d_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving during the response cycle still cancels the fetch pulse.
  assign if_done    = if_done_r & ~if_flush;
  assign d_done     = d_done_r;
  assign if_rdata   = if_rdata_r;
  assign d_rdata    = d_rdata_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_funct3 = funct3_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign busy       = (state_r != ST_IDLE);
  assign owner      = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small word-addressed memory model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_funct3;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  assign mem_rdata = mem_en ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 16'h0000; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 16'h0000; d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests_run++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem got en=%0b we=%0b exp 0/0", mem_en, mem_we); end
    tests_run++; if (if_done !== 1'b0 || d_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b/%0b exp 0/0", if_done, d_done); end
    tests_run++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, d_rdata); end
    tests_run++; if (owner !== 1'b0) begin tests_failed++; $display("FAIL reset_owner got %0b exp 0", owner); end
  endtask

  task automatic test_fetch();
    mem[4] = 32'h00500093;
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    tests_run++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || owner !== 1'b0) begin tests_failed++; $display("FAIL fetch_t1 got en=%0b we=%0b own=%0b exp 1/0/0", mem_en, mem_we, owner); end
    tests_run++; if (mem_addr !== 16'h0010 || mem_funct3 !== 3'b010) begin tests_failed++; $display("FAIL fetch_payload got addr=%h f3=%0d exp 0010/2", mem_addr, mem_funct3); end
    step();
    tests_run++; if (mem_en !== 1'b1 || if_done !== 1'b0) begin tests_failed++; $display("FAIL fetch_t2 got en=%0b done=%0b exp 1/0", mem_en, if_done); end
    step();
    tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL fetch_done got done=%0b data=%h exp 1/00500093", if_done, if_rdata); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL fetch_en_off got %0b exp 0", mem_en); end
    if_req = 1'b0;
    step();
    tests_run++; if (if_done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL fetch_idle got done=%0b busy=%0b exp 0/0", if_done, busy); end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
    step();
    tests_run++; if (mem_we !== 1'b1 || owner !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL store_t1 got we=%0b own=%0b addr=%h wd=%h exp 1/1/0100/deadbeef", mem_we, owner, mem_addr, mem_wdata); end
    step();
    tests_run++; if (mem_we !== 1'b0 || mem_en !== 1'b1) begin tests_failed++; $display("FAIL store_t2 got we=%0b en=%0b exp 0/1", mem_we, mem_en); end
    step();
    tests_run++; if (d_done !== 1'b1 || d_rdata !== 32'h0 || if_done !== 1'b0) begin tests_failed++; $display("FAIL store_done got done=%0b rd=%h ifd=%0b exp 1/0/0", d_done, d_rdata, if_done); end
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0;
    step();
    tests_run++; if (mem_we !== 1'b0 || owner !== 1'b1) begin tests_failed++; $display("FAIL load_t1 got we=%0b own=%0b exp 0/1", mem_we, owner); end
    step(); step();
    tests_run++; if (d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_done got done=%0b rd=%h exp 1/deadbeef", d_done, d_rdata); end
    d_req = 1'b0;
    step();
    tests_run++; if (d_done !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_hold got done=%0b rd=%h exp 0/deadbeef", d_done, d_rdata); end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    step();
    tests_run++; if (owner !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL contend_first got own=%0b busy=%0b exp 1/1", owner, busy); end
    step(); step();
    tests_run++; if (d_done !== 1'b1 || if_done !== 1'b0) begin tests_failed++; $display("FAIL contend_ddone got d=%0b if=%0b exp 1/0", d_done, if_done); end
    d_req = 1'b0;
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL contend_idle got busy=%0b exp 0", busy); end
    step();
    tests_run++; if (owner !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL contend_second got own=%0b busy=%0b exp 0/1", owner, busy); end
    step(); step();
    tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL contend_ifdone got done=%0b data=%h exp 1/00500093", if_done, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++; if (owner !== ((k < 4) ? 1'b1 : 1'b0)) begin tests_failed++; $display("FAIL starve_owner_%0d got %0b exp %0b", k, owner, (k < 4) ? 1'b1 : 1'b0); end
      if (k == 3) begin
        tests_run++; if (dut.starve_cnt_r !== 3'd4) begin tests_failed++; $display("FAIL starve_cnt_max got %0d exp 4", dut.starve_cnt_r); end
      end
      if (k == 4) begin
        tests_run++; if (dut.starve_cnt_r !== 3'd0) begin tests_failed++; $display("FAIL starve_cnt_clear got %0d exp 0", dut.starve_cnt_r); end
      end
      step(); step();
      tests_run++; if ({d_done, if_done} !== ((k < 4) ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL starve_done_%0d got %b exp %b", k, {d_done, if_done}, (k < 4) ? 2'b10 : 2'b01); end
      if (k == 4) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_flush();
    mem[4] = 32'h12345678;
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    if_flush = 1'b1; if_req = 1'b0;
    tests_run++; if (busy !== 1'b1 || owner !== 1'b0) begin tests_failed++; $display("FAIL flush_granted got busy=%0b own=%0b exp 1/0", busy, owner); end
    step();
    if_flush = 1'b0;
    tests_run++; if (mem_en !== 1'b1) begin tests_failed++; $display("FAIL flush_runs got en=%0b exp 1", mem_en); end
    step();
    tests_run++; if (if_done !== 1'b0 || if_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL flush_suppress got done=%0b data=%h exp 0/00500093", if_done, if_rdata); end
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_idle got busy=%0b exp 0", busy); end
    if_req = 1'b1; if_flush = 1'b1;
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_block got busy=%0b exp 0", busy); end
    if_flush = 1'b0;
    step();
    tests_run++; if (busy !== 1'b1 || owner !== 1'b0) begin tests_failed++; $display("FAIL flush_regrant got busy=%0b own=%0b exp 1/0", busy, owner); end
    step(); step();
    tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL flush_refetch got done=%0b data=%h exp 1/12345678", if_done, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    step();
    tests_run++; if (busy !== 1'b1 || owner !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy got busy=%0b own=%0b exp 1/1", busy, owner); end
    rst = 1'b1; d_req = 1'b0;
    step();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0 || mem_en !== 1'b0) begin tests_failed++; $display("FAIL rmid_state got busy=%0b en=%0b exp 0/0", busy, mem_en); end
    tests_run++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin tests_failed++; $display("FAIL rmid_rdata got %h/%h exp 0/0", d_rdata, if_rdata); end
    for (int i = 0; i < 4; i++) begin
      if (d_done !== 1'b0) seen_done++;
      step();
    end
    tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL rmid_no_done got %0d pulses exp 0", seen_done); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_starvation();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
